// File: rtl/window_pkg.sv
// Shared types and constants for the 5x5 window producer.
// Holds the FSM state encoding and the packed-window indexing helper.
package window_pkg;

  localparam int DEF_DATA_WIDTH = 14;
  localparam int WIN_K          = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_t;

  // Bit offset of window element (row r, column c); row 0 / column 0 are the oldest.
  function automatic int win_idx(input int r, input int c, input int dw = DEF_DATA_WIDTH);
    return (r * WIN_K + c) * dw;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Four line buffers of IMG_W pixels, read combinationally at the current column.
// A write shifts the column upward, so line 0 always holds the oldest row.
module line_buffer
  import window_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_W      = 256,
  parameter int XW         = $clog2(IMG_W)
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [XW-1:0]           i_col,
  input  logic [DATA_WIDTH-1:0]   i_pixel,
  output logic [4*DATA_WIDTH-1:0] o_taps
);

  logic [DATA_WIDTH-1:0] r_mem [4][IMG_W];

  always_comb begin
    o_taps = '0;
    for (int k = 0; k < 4; k++) begin
      o_taps[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[k][i_col];
    end
  end

  // NOTE: storage arrays get no reset; rows from a previous frame are
  // fully overwritten before any window can use them.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int k = 0; k < 3; k++) begin
        r_mem[k][i_col] <= r_mem[k+1][i_col];
      end
      r_mem[3][i_col] <= i_pixel;
    end
  end

endmodule

// File: rtl/window_gen5.sv
// Raster pixel stream to packed 5x5 interior windows with centre address.
// Backpressure is applied upstream through in_pixel_ready; there is no output queue.
module window_gen5
  import window_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      in_pixel_value,
  input  logic                       in_pixel_valid,
  input  logic                       in_pixel_sof,
  output logic                       in_pixel_ready,
  input  logic                       window_req,
  output logic [DATA_WIDTH*25-1:0]   out_window_value,
  output logic                       out_window_valid,
  output logic [15:0]                out_window_addr,
  output logic                       out_frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  state_t                  r_state;
  logic [XW-1:0]           r_x;
  logic [YW-1:0]           r_y;
  logic [DATA_WIDTH-1:0]   r_win [WIN_K][WIN_K];

  logic                    w_accept;
  logic                    w_take;
  logic                    w_emit;
  logic                    w_last;
  logic [XW-1:0]           w_x;
  logic [YW-1:0]           w_y;
  logic [4*DATA_WIDTH-1:0] w_taps;
  logic [DATA_WIDTH-1:0]   w_win_next [WIN_K][WIN_K];
  logic [DATA_WIDTH*25-1:0] w_pack;
  logic [15:0]             w_addr;

  assign in_pixel_ready = window_req & (r_state != DONE);
  assign w_accept       = in_pixel_valid & in_pixel_ready;
  // Non-sof pixels seen while IDLE are accepted but never enter the datapath.
  assign w_take         = w_accept & (in_pixel_sof | (r_state == ACTIVE));
  assign w_x            = in_pixel_sof ? '0 : r_x;
  assign w_y            = in_pixel_sof ? '0 : r_y;
  assign w_emit         = w_take & (w_x >= XW'(4)) & (w_y >= YW'(4));
  assign w_last         = w_take & (w_x == XW'(IMG_W - 1)) & (w_y == YW'(IMG_H - 1));
  assign w_addr         = 16'((int'(w_y) - 2) * IMG_W + int'(w_x) - 2);

  line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_W      (IMG_W),
    .XW         (XW)
  ) u_line_buffer (
    .clk     (clk),
    .i_we    (w_take & ~rst),
    .i_col   (w_x),
    .i_pixel (in_pixel_value),
    .o_taps  (w_taps)
  );

  always_comb begin
    for (int r = 0; r < WIN_K; r++) begin
      for (int c = 0; c < WIN_K - 1; c++) begin
        w_win_next[r][c] = r_win[r][c+1];
      end
    end
    for (int r = 0; r < WIN_K - 1; r++) begin
      w_win_next[r][WIN_K-1] = w_taps[r*DATA_WIDTH +: DATA_WIDTH];
    end
    w_win_next[WIN_K-1][WIN_K-1] = in_pixel_value;
  end

  always_comb begin
    w_pack = '0;
    for (int r = 0; r < WIN_K; r++) begin
      for (int c = 0; c < WIN_K; c++) begin
        w_pack[win_idx(r, c, DATA_WIDTH) +: DATA_WIDTH] = w_win_next[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_take) begin
      r_win <= w_win_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_x              <= '0;
      r_y              <= '0;
      out_window_valid <= 1'b0;
      out_window_value <= '0;
      out_window_addr  <= '0;
      out_frame_done   <= 1'b0;
    end else begin
      out_window_valid <= w_emit;
      out_frame_done   <= 1'b0;
      if (w_emit) begin
        out_window_value <= w_pack;
        out_window_addr  <= w_addr;
      end
      if (r_state == DONE) begin
        r_state <= IDLE;
      end else if (w_take) begin
        // A sof pixel restarts the frame at (0,0) even mid-frame.
        if (in_pixel_sof) begin
          r_state <= ACTIVE;
          r_x     <= XW'(1);
          r_y     <= '0;
        end else if (w_last) begin
          r_state        <= DONE;
          r_x            <= '0;
          r_y            <= '0;
          out_frame_done <= 1'b1;
        end else if (r_x == XW'(IMG_W - 1)) begin
          r_x <= '0;
          r_y <= r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end
    end
  end

endmodule

// File: doc/window_gen5.md
Name: window_gen5

Overview:
- Producer end of the 5x5 window interface: turns a raster pixel stream into packed 5x5 windows plus centre address.
- Drives the Gaussian/event stage (in_window_value / in_window_valid / in_window_addr) and honours that stage's window_req.
- Holds 4 line buffers and a 5x5 shift window.
- Emits only interior windows, i.e. those fully inside the frame.

Parameters:
- DATA_WIDTH, 14, bits per pixel/window element.
- IMG_W, 256, frame width in pixels (>=5).
- IMG_H, 256, frame height in pixels (>=5); IMG_W*IMG_H <= 65536.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_pixel_value  in  DATA_WIDTH  raster pixel.
- in_pixel_valid  in  1  pixel present.
- in_pixel_sof  in  1  qualifies pixel as (x=0,y=0) of a new frame.
- in_pixel_ready  out  1  pixel accepted when valid&ready.
- window_req  in  1  downstream ready for a new window (level).
- out_window_value  out  DATA_WIDTH*25  packed window.
- out_window_valid  out  1  one-cycle pulse per window.
- out_window_addr  out  16  centre address y*IMG_W+x.
- out_frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (sync, rst=1): all outputs 0, state IDLE, counters 0. Line buffer contents are don't-care.
- in_pixel_ready = window_req & (state != DONE), combinational. With window_req low, nothing is accepted and all state is frozen.
- States:
  - IDLE: wait for accepted pixel with sof=1; non-sof pixels are accepted and dropped. On sof go to ACTIVE with x=1,y=0 (sof pixel stored as (0,0)).
  - ACTIVE: each accepted pixel is written at (x,y); x increments, wraps at IMG_W-1 to 0 and increments y. Accepting (IMG_W-1,IMG_H-1) goes to DONE.
  - DONE: one cycle; out_frame_done=1; back to IDLE.
- sof=1 accepted while ACTIVE: frame resync. Pixel taken as (0,0) and counters restart. No window is emitted for that pixel. No out_frame_done for the aborted frame.
- Window datapath:
  - Per accepted pixel, 5 row shift registers shift left.
  - Row 4 takes the incoming pixel; rows 0..3 take line buffer outputs for column x, rows y-4..y-1.
  - The line buffer column x is then rewritten: line k <- line k+1, line 3 <- pixel.
- Packing: row r (0=top/oldest) occupies bits [DW*5*(r+1)-1 : DW*5*r]; column c (0=leftmost/oldest) within row at offset DW*c.
- Emission:
  - Accepting pixel (x,y) with x>=4 and y>=4 drives out_window_valid=1 on the next cycle.
  - Window centred at (x-2,y-2); out_window_addr=(y-2)*IMG_W+(x-2).
  - Otherwise valid=0 and value/addr hold their previous value.
- Latency: 1 cycle from acceptance to window. Per frame exactly (IMG_W-4)*(IMG_H-4) windows.
- Simultaneous rst and valid pixel: rst wins; pixel dropped.
- Reset mid-frame: returns to IDLE; next frame needs sof.
- No overflow is possible: the block has no output FIFO; backpressure is pushed upstream via in_pixel_ready.

Decomposition:
- Shared package window_pkg: DATA_WIDTH default, WIN_K=5, state enum {IDLE,ACTIVE,DONE}, packing index function win_idx(r,c)=(r*5+c)*DATA_WIDTH.
- Sub-module line_buffer: 4 lines x IMG_W x DATA_WIDTH with read-before-write per column. Register array or inferred RAM with 1-cycle read is acceptable; a RAM must be prefetched with x so the 1-cycle latency holds.

Test Plan:
- IMG_W=IMG_H=8, pixel=y*8+x, sof on first pixel, window_req=1 -> first window one cycle after pixel 36 accepted; addr=18; element (r,c)=r*8+c, centre element=18; 16 windows total; last addr=45.
- Same frame, window_req toggled 0 every 3rd cycle -> in_pixel_ready tracks window_req; identical 16 windows, values and order as in the first scenario, none lost or duplicated.
- Stream frame, out_frame_done -> exactly one pulse, the cycle after pixel 63 is accepted; state back to IDLE; 5 non-sof pixels then dropped with no windows.
- sof reasserted at pixel 40 of a frame -> no done pulse for the aborted frame; next window is 36 pixels after the resync pixel, with addr=18.
- rst=1 for one cycle at pixel 30 -> all outputs 0 next cycle; subsequent full frame with sof produces the 16 correct windows.
- Two back-to-back frames, no gap, sof on each first pixel -> 32 windows. The second frame's first window contains only second-frame values, with no stale rows.
